logic_unit_pipe: RTL and testbench
==================================

// Module: logic_unit_pipe
// PURPOSE
//   Parametrised, pipelined bitwise logic unit; successor to the combinational AND gate.
//   Computes one of eight bitwise ops on WIDTH-bit operands behind a valid/ready handshake.
//   Has one output register plus a 1-entry skid buffer, giving full throughput under backpressure.
//   Sits in the CPU execute stage next to the adder; also usable standalone in SOC peripherals.
// PARAMETERS
//   WIDTH   32   operand/result width in bits (>=1)
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous reset, active-high
//   in_valid   in   1      operand beat valid
//   in_ready   out  1      unit accepts beat this cycle
//   op         in   3      operation select, sampled with a/b
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts result
//   c          out  WIDTH  result
//   zero       out  1      c == 0 (only with LOGIC_ZERO_FLAG_EN)
// BEHAVIOUR
//   - Ops: 000 a&b, 001 a|b, 010 a^b, 011 ~(a|b), 100 a&~b, 101 a, 110 ~a, 111 all-zero.
//   - Input handshake: a beat transfers when in_valid & in_ready at a clk edge.
//     Output handshake: a beat transfers when out_valid & out_ready at a clk edge.
//   - Latency: 1 cycle. A beat accepted at edge N shows on c/out_valid after edge N
//     if the output register is free or is draining at N.
//   - State: out register (out_valid, c) and skid register (skid_valid, skid_c).
//   - in_ready = ~skid_valid. It is combinational from a register, never from out_ready.
//   - Per edge, when the output is empty or draining (~out_valid | out_ready):
//       - skid_valid: out <= skid, skid_valid <= 0, and any accepted beat goes into skid.
//       - else if an input is accepted: out <= result.
//       - else: out_valid <= 0.
//   - Per edge, when the output is stalled (out_valid & ~out_ready) and an input is
//     accepted: skid <= result, skid_valid <= 1.
//   - Simultaneous accept and drain with skid empty: the new result replaces c directly and
//     out_valid stays 1. Back-to-back beats therefore sustain 1 result per cycle.
//   - Ordering: results leave in acceptance order; no beat is dropped or duplicated.
//   - c is held stable while out_valid & ~out_ready.
//   - Reset, asserted at any time including mid-transfer:
//       - out_valid = 0, skid_valid = 0, c = 0, zero = 1.
//       - in_ready = 1 from the first edge after release.
//       - In-flight beats are discarded.
//   - op values are all defined, so there is no illegal-op state.
//   - WIDTH = 1 is legal; all ops apply per bit.
// CONFIGURATION
//   - LOGIC_ZERO_FLAG_EN defined:
//       - zero port present.
//       - zero is registered alongside c and equals (c == 0) whenever out_valid = 1.
//       - zero follows the skid path as well.
//       - zero resets to 1.
//   - LOGIC_ZERO_FLAG_EN undefined: zero port and its registers are absent; all other
//     behaviour is unchanged.
// TESTING
//   1. Reset with rst=1 for 3 cycles, then release -> out_valid=0, c=0, in_ready=1,
//      zero=1 (if EN).
//   2. WIDTH=32, out_ready=1; send op=000 a=FFFFFFFF b=007FA509, then op=010 a=FFFFFFFF
//      b=0000FFFF on consecutive cycles -> c=007FA509 then FFFF0000 on consecutive
//      cycles, out_valid high throughout.
//   3. out_ready=0; send op=001 a=00000000 b=FFFFFFFF, then op=011 with the same operands
//      -> c=FFFFFFFF held, in_ready=0 after the 2nd beat. Raise out_ready -> c=FFFFFFFF,
//      then 00000000 with zero=1, then in_ready=1.
//   4. Sweep all 8 ops with a=F0F0A5A5 b=FF00FF00 -> c=F000A500, FFF0FFA5, 0FF05AA5,
//      000F005A, 00F000A5, F0F0A5A5, 0F0F5A5A, 00000000.
//   5. Random in_valid/out_ready (10k beats, random op/a/b) vs a scoreboard FIFO ->
//      every result matches in order, no loss or duplication, c stable during stalls.
//   6. Assert rst while the skid is full and out_valid=1 -> out_valid=0 and
//      skid_valid=0 immediately (async). After release, no stale result is ever emitted.

Source files
------------

// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bundle for logic_unit_pipe.
// The zero flag exists only when LOGIC_ZERO_FLAG_EN is defined.
interface logic_unit_pipe_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] c;
`ifdef LOGIC_ZERO_FLAG_EN
  logic             zero;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, c, zero
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, c, zero
  );
`else
  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, c
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, c
  );
`endif
endinterface

// File: rtl/logic_unit_pipe.sv
// Pipelined 8-op bitwise logic unit: output register plus 1-entry skid buffer.
// Optional registered zero flag enabled by defining LOGIC_ZERO_FLAG_EN.
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  logic_unit_pipe_if.slave   bus
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_c;
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_skid_c;

  logic             w_accept;
  logic             w_out_free;
  logic             w_out_from_skid;
  logic             w_out_from_in;
  logic             w_load_skid;
  logic [WIDTH-1:0] w_result;

  always_comb begin
    w_result = '0;
    case (bus.op)
      3'b000:  w_result = bus.a & bus.b;
      3'b001:  w_result = bus.a | bus.b;
      3'b010:  w_result = bus.a ^ bus.b;
      3'b011:  w_result = ~(bus.a | bus.b);
      3'b100:  w_result = bus.a & ~bus.b;
      3'b101:  w_result = bus.a;
      3'b110:  w_result = ~bus.a;
      default: w_result = '0;
    endcase
  end

  // Ready depends only on skid occupancy, so out_ready never reaches in_ready.
  assign bus.in_ready    = ~r_skid_valid;
  assign w_accept        = bus.in_valid & ~r_skid_valid;
  assign w_out_free      = ~r_out_valid | bus.out_ready;
  assign w_out_from_skid = w_out_free & r_skid_valid;
  assign w_out_from_in   = w_out_free & ~r_skid_valid & w_accept;
  assign w_load_skid     = ~w_out_free & w_accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_c          <= '0;
      r_skid_valid <= 1'b0;
      r_skid_c     <= '0;
    end else begin
      if (w_out_free) begin
        r_out_valid <= w_out_from_skid | w_out_from_in;
      end
      if (w_out_from_skid) begin
        r_c          <= r_skid_c;
        r_skid_valid <= 1'b0;
      end else if (w_out_from_in) begin
        r_c <= w_result;
      end
      if (w_load_skid) begin
        r_skid_c     <= w_result;
        r_skid_valid <= 1'b1;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.c         = r_c;

`ifdef LOGIC_ZERO_FLAG_EN
  logic r_zero;
  logic r_skid_zero;
  logic w_zero;

  assign w_zero = (w_result == '0);

  // Zero flag travels with its result through the same out/skid path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_zero      <= 1'b1;
      r_skid_zero <= 1'b1;
    end else begin
      if (w_out_from_skid) begin
        r_zero <= r_skid_zero;
      end else if (w_out_from_in) begin
        r_zero <= w_zero;
      end
      if (w_load_skid) begin
        r_skid_zero <= w_zero;
      end
    end
  end

  assign bus.zero = r_zero;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: queue-based reference model plus directed literal checks.
module tb_logic_unit_pipe;
  localparam int unsigned WIDTH = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic_unit_pipe_if #(.WIDTH(WIDTH)) bus ();

  logic_unit_pipe #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_acc    = 0;
  int n_out    = 0;

  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] got_c[$];
  logic             got_z[$];
  int               got_cyc[$];
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_c     = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] model(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    r = '0;
    if (op == 3'd0) r = a & b;
    if (op == 3'd1) r = a | b;
    if (op == 3'd2) r = a ^ b;
    if (op == 3'd3) r = ~(a | b);
    if (op == 3'd4) r = a & ~b;
    if (op == 3'd5) r = a;
    if (op == 3'd6) r = ~a;
    return r;
  endfunction

  // Compare process: state after the last edge, then transfers at the next edge.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      prev_stall = 1'b0;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_c", 32'(bus.c), 32'd0);
`ifdef LOGIC_ZERO_FLAG_EN
      check("rst_zero", 32'(bus.zero), 32'd1);
`endif
    end else begin
      check("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
      check("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
      if (bus.out_valid && q.size() > 0) begin
        check("c_order", 32'(bus.c), 32'(q[0]));
`ifdef LOGIC_ZERO_FLAG_EN
        check("zero_flag", 32'(bus.zero), 32'(q[0] == '0));
`endif
      end
      if (prev_stall) begin
        check("stall_valid", 32'(bus.out_valid), 32'd1);
        check("stall_c", 32'(bus.c), 32'(prev_c));
      end
      if (bus.out_valid && bus.out_ready && q.size() > 0) begin
        got_c.push_back(bus.c);
`ifdef LOGIC_ZERO_FLAG_EN
        got_z.push_back(bus.zero);
`else
        got_z.push_back(bus.c == '0);
`endif
        got_cyc.push_back(cyc);
        void'(q.pop_front());
        n_out++;
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(bus.op, bus.a, bus.b));
        n_acc++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_c     = bus.c;
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic rdy;
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a  = a;
    bus.b  = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      if (rdy) return;
    end
    check("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [WIDTH-1:0] sweep_exp [8];
  int base;
  int guard;

  initial begin
    sweep_exp[0] = 32'hF000A500; sweep_exp[1] = 32'hFFF0FFA5;
    sweep_exp[2] = 32'h0FF05AA5; sweep_exp[3] = 32'h000F005A;
    sweep_exp[4] = 32'h00F000A5; sweep_exp[5] = 32'hF0F0A5A5;
    sweep_exp[6] = 32'h0F0F5A5A; sweep_exp[7] = 32'h00000000;

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.op = 3'd0; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t1_out_valid", 32'(bus.out_valid), 32'd0);
    check("t1_c", 32'(bus.c), 32'd0);
    check("t1_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef LOGIC_ZERO_FLAG_EN
    check("t1_zero", 32'(bus.zero), 32'd1);
`endif
    @(posedge clk); #1;

    // Back-to-back throughput
    base = got_c.size();
    send(3'b000, 32'hFFFFFFFF, 32'h007FA509);
    send(3'b010, 32'hFFFFFFFF, 32'h0000FFFF);
    idle_cycles(3);
    check("t2_count", 32'(got_c.size() - base), 32'd2);
    if (got_c.size() >= base + 2) begin
      check("t2_c0", got_c[base], 32'h007FA509);
      check("t2_c1", got_c[base+1], 32'hFFFF0000);
      check("t2_consecutive", 32'(got_cyc[base+1] - got_cyc[base]), 32'd1);
    end

    // Backpressure fills the skid
    bus.out_ready = 1'b0;
    base = got_c.size();
    send(3'b001, 32'h00000000, 32'hFFFFFFFF);
    send(3'b011, 32'h00000000, 32'hFFFFFFFF);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("t3_held_c", 32'(bus.c), 32'hFFFFFFFF);
    check("t3_in_ready_low", 32'(bus.in_ready), 32'd0);
    check("t3_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #1;
    idle_cycles(2);
    bus.out_ready = 1'b1;
    idle_cycles(3);
    check("t3_count", 32'(got_c.size() - base), 32'd2);
    if (got_c.size() >= base + 2) begin
      check("t3_c0", got_c[base], 32'hFFFFFFFF);
      check("t3_c1", got_c[base+1], 32'h00000000);
      check("t3_zero", 32'(got_z[base+1]), 32'd1);
    end
    check("t3_in_ready_back", 32'(bus.in_ready), 32'd1);

    // Op sweep
    base = got_c.size();
    for (int i = 0; i < 8; i++) send(3'(i), 32'hF0F0A5A5, 32'hFF00FF00);
    idle_cycles(3);
    check("t4_count", 32'(got_c.size() - base), 32'd8);
    for (int i = 0; i < 8; i++)
      if (got_c.size() > base + i) check($sformatf("t4_op%0d", i), got_c[base+i], sweep_exp[i]);

    // Randomized traffic with backpressure
    base  = n_acc;
    guard = 0;
    while ((n_acc - base) < 10000 && guard < 60000) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.op        = 3'($urandom_range(0, 7));
      bus.a         = $urandom;
      bus.b         = $urandom;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      guard++;
    end
    check("t5_budget", 32'(guard < 60000), 32'd1);
    bus.out_ready = 1'b1;
    idle_cycles(4);
    check("t5_drained", 32'(q.size()), 32'd0);
    check("t5_in_eq_out", 32'(n_out), 32'(n_acc));

    // Async reset with skid full
    bus.out_ready = 1'b0;
    send(3'b101, 32'h12345678, 32'h0);
    send(3'b110, 32'h12345678, 32'h0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_async_valid", 32'(bus.out_valid), 32'd0);
    check("t6_async_in_ready", 32'(bus.in_ready), 32'd1);
    check("t6_async_c", 32'(bus.c), 32'd0);
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    base = got_c.size();
    idle_cycles(5);
    check("t6_no_stale", 32'(got_c.size() - base), 32'd0);
    send(3'b010, 32'hAAAA5555, 32'h0F0F0F0F);
    idle_cycles(2);
    check("t6_after_count", 32'(got_c.size() - base), 32'd1);
    if (got_c.size() > base) check("t6_after_c", got_c[base], 32'hA5A55A5A);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
